// File: rtl/led_display_arbiter.sv
// Round-robin owner of one LED bank: grants a pattern source with a valid/ready
// handshake, latches its pattern and holds it for HOLD_CYCLES before re-arbitrating.
module led_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]                   req_pattern,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic                                       blank,
    output logic [WIDTH-1:0]                           led_out,
    output logic [(NUM_REQ>1?$clog2(NUM_REQ):1)-1:0]   owner,
    output logic                                       busy,
    output logic                                       done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t                   state;
    logic [PW-1:0]            ptr;
    logic [CW-1:0]            cnt;
    logic [PW-1:0]            win;
    logic [PW-1:0]            nxt;
    logic                     found;
    logic                     grant;
    logic [WIDTH-1:0]         win_pat;
    logic [2*NUM_REQ-1:0]     rot;

    // Rotate the request vector so bit 0 is the requester at ptr.
    always_comb begin
        int s;
        s     = 0;
        found = 1'b0;
        win   = '0;
        rot   = {req_valid, req_valid} >> ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                s     = int'(ptr) + k;
                if (s >= NUM_REQ) begin
                    s = s - NUM_REQ;
                end
                win = PW'(s);
            end
        end
    end

    always_comb begin
        win_pat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == win) begin
                win_pat = req_pattern[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant = (state == IDLE) && found && !blank && !rst;
    assign nxt   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    assign busy  = (state == SHOW);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (PW'(i) == win);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            led_out <= '0;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (blank) begin
                        led_out <= '0;
                    end else if (grant) begin
                        led_out <= win_pat;
                        owner   <= win;
                        ptr     <= nxt;
                        cnt     <= CW'(HOLD_CYCLES - 1);
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    // An abort outranks normal expiry and never signals done.
                    if (blank) begin
                        led_out <= '0;
                        state   <= IDLE;
                    end else if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Randomised and directed bench for led_display_arbiter (HOLD 4 and HOLD 1),
// checked against a remaining-time reference model and a grant scoreboard.
module tb_led_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_pattern;
    logic        blank;

    logic [3:0]  ready4, ready1;
    logic [7:0]  led4, led1;
    logic [1:0]  owner4, owner1;
    logic        busy4, busy1, done4, done1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         rem;
        int         ptr;
        logic [7:0] led;
        int         owner;
        logic       done;
    } mdl_t;

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] led;
    } exp_t;

    mdl_t m4, m1;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    led_display_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_pattern(req_pattern), .req_ready(ready4), .blank(blank),
        .led_out(led4), .owner(owner4), .busy(busy4), .done(done4)
    );

    led_display_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_pattern(req_pattern), .req_ready(ready1), .blank(blank),
        .led_out(led1), .owner(owner1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input mdl_t m, input logic [3:0] v,
                                             input logic b, input logic r);
        int w;
        w = pick(m.ptr, v);
        if (m.rem == 0 && !b && !r && w >= 0) return 4'b0001 << w;
        return 4'b0000;
    endfunction

    // rem counts display cycles still owed; zero means the bank is free.
    function automatic void step(inout mdl_t m, input int hold,
                                 input logic [3:0] v, input logic [31:0] p,
                                 input logic b, input logic r, output int w);
        w = -1;
        if (r) begin
            m.rem = 0; m.ptr = 0; m.led = 0; m.owner = 0; m.done = 0;
            return;
        end
        m.done = 0;
        if (m.rem > 0) begin
            if (b) begin
                m.led = 0;
                m.rem = 0;
            end else begin
                m.rem--;
                if (m.rem == 0) m.done = 1;
            end
        end else if (b) begin
            m.led = 0;
        end else begin
            w = pick(m.ptr, v);
            if (w >= 0) begin
                m.led   = p[w*8 +: 8];
                m.owner = w;
                m.ptr   = (w + 1) % 4;
                m.rem   = hold;
            end
        end
    endfunction

    task automatic cyc(input logic [3:0] v, input logic b, input logic r);
        int   w4, w1;
        exp_t e;
        req_valid = v;
        blank     = b;
        rst       = r;
        #1;
        check("ready4", ready4, exp_ready(m4, v, b, r));
        check("ready1", ready1, exp_ready(m1, v, b, r));
        step(m4, 4, v, req_pattern, b, r, w4);
        step(m1, 1, v, req_pattern, b, r, w1);
        if (w4 >= 0) begin
            e.own = 2'(w4);
            e.led = m4.led;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("busy4", busy4, m4.rem > 0);
        check("done4", done4, m4.done);
        check("led4", led4, m4.led);
        check("owner4", owner4, m4.owner);
        check("busy1", busy1, m1.rem > 0);
        check("done1", done1, m1.done);
        check("led1", led1, m1.led);
        check("owner1", owner1, m1.owner);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, 1'b0);
    endtask

    // Monitor: every handshake on dut4 must match the next queued grant,
    // and the LED bank must show that grant on the following cycle.
    initial begin
        exp_t pend;
        logic has_pend;
        has_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (has_pend) begin
                check("sb_led", led4, pend.led);
                check("sb_owner", owner4, pend.own);
                has_pend = 1'b0;
            end
            if (ready4 != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_grant", ready4, 4'b0000);
                end else begin
                    pend = exp_q.pop_front();
                    check("sb_grant", ready4, 4'b0001 << pend.own);
                    has_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        m4 = '{rem: 0, ptr: 0, led: 8'h00, owner: 0, done: 1'b0};
        m1 = m4;
        req_valid   = 4'b0000;
        req_pattern = 32'h0;
        blank       = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b1);
        check("reset_led", led4, 8'h00);
        check("reset_busy", busy4, 1'b0);

        req_pattern = 32'h0000_0001;
        cyc(4'b0001, 1'b0, 1'b0);
        check("first_led", led4, 8'h01);
        idle(6);

        req_pattern = 32'h8844_2211;
        for (int i = 0; i < 25; i++) cyc(4'b1111, 1'b0, 1'b0);
        idle(5);

        for (int i = 0; i < 10; i++) cyc(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(4'b1010, 1'b0, 1'b0);
        idle(5);

        cyc(4'b0001, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        check("blank_led", led4, 8'h00);
        check("blank_done", done4, 1'b0);
        idle(2);

        cyc(4'b0001, 1'b0, 1'b0);
        idle(3);
        cyc(4'b0000, 1'b1, 1'b0);
        check("blank_expiry_done", done4, 1'b0);
        idle(2);

        for (int i = 0; i < 4; i++) cyc(4'b1111, 1'b1, 1'b0);

        cyc(4'b0100, 1'b0, 1'b0);
        check("pre_reset_led", led4, 8'h44);
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b0);
        check("post_reset_owner", owner4, 2'd0);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            req_pattern = $urandom;
            cyc(4'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 63) == 0));
        end
        idle(6);
        @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
